// File: rtl/menu_cursor_ctrl.sv
// ---------------------------------------------------------------------------
// menu_cursor_ctrl
//
// This block handles menu navigation. It sits directly behind the push-button
// debouncers. It takes the debounced held-state and the one-cycle press pulses
// for UP, DOWN and SELECT. From these it maintains a wrapping cursor index.
// While UP or DOWN is held, the cursor repeats its steps typematically. On
// SELECT, the block sends a one-cycle strobe carrying the chosen index to the
// menu renderer.
//
// Parameters
//   N_ITEMS    number of menu entries, cursor range 0..N_ITEMS-1 (>= 2)
//   DELAY_CYC  cycles held after the first step before repeating starts (>= 2)
//   RATE_CYC   cycles between repeat steps (>= 2)
//   CW         cursor width, derived from N_ITEMS
//
// Ports
//   clk        system clock
//   reset      synchronous, active-high reset
//   enable     1 = menu active, 0 = all buttons ignored and FSM parked
//   up_state   debounced UP held level
//   up_press   one-cycle UP press pulse
//   dn_state   debounced DOWN held level
//   dn_press   one-cycle DOWN press pulse
//   sel_press  one-cycle SELECT press pulse
//   cursor     registered highlighted entry
//   moved      one-cycle pulse, high in the cycle cursor shows a new value
//   select     one-cycle select strobe
//   sel_index  index captured with select, held until the next select
// ---------------------------------------------------------------------------
module menu_cursor_ctrl #(
  parameter int N_ITEMS   = 8,
  parameter int DELAY_CYC = 12500000,
  parameter int RATE_CYC  = 2500000,
  localparam int CW       = $clog2(N_ITEMS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          up_state,
  input  logic          up_press,
  input  logic          dn_state,
  input  logic          dn_press,
  input  logic          sel_press,
  output logic [CW-1:0] cursor,
  output logic          moved,
  output logic          select,
  output logic [CW-1:0] sel_index
);

  // Width of the hold counter. It covers the larger of the two intervals.
  localparam int MAX_CYC = (DELAY_CYC > RATE_CYC) ? DELAY_CYC : RATE_CYC;
  localparam int CNTW    = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [CNTW-1:0] DELAY_LAST = CNTW'(DELAY_CYC - 1);
  localparam logic [CNTW-1:0] RATE_LAST  = CNTW'(RATE_CYC - 1);
  localparam logic [CW-1:0]   LAST_ITEM  = CW'(N_ITEMS - 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DELAY  = 2'd1;
  localparam logic [1:0] REPEAT = 2'd2;

  logic [1:0]      state, state_n;
  logic            dir, dir_n;        // 0 = UP, 1 = DOWN
  logic [CNTW-1:0] cnt, cnt_n;

  logic            held;
  logic            one_press;
  logic            both_press;
  logic            opp_press;
  logic            limit_hit;
  logic            step;
  logic            step_dir;
  logic [CW-1:0]   cursor_n;
  logic            sel_fire;

  // Button qualification. These signals are computed relative to the
  // direction currently being held.
  always_comb begin
    held       = dir ? dn_state : up_state;
    one_press  = up_press ^ dn_press;
    both_press = up_press & dn_press;
    opp_press  = dir ? (up_press & ~dn_press) : (dn_press & ~up_press);
    limit_hit  = (state == DELAY) ? (cnt == DELAY_LAST) : (cnt == RATE_LAST);
  end

  // Next-state logic for the typematic FSM. The checks in the DELAY/REPEAT
  // branch are in deliberate priority order. A reversal beats a double press.
  // A double press beats a release. A release beats an expired interval, so
  // letting go exactly on the limit cycle never produces a step.
  always_comb begin
    state_n  = state;
    dir_n    = dir;
    cnt_n    = cnt;
    step     = 1'b0;
    step_dir = dir;

    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          cnt_n = '0;
          if (one_press) begin
            step     = 1'b1;
            step_dir = dn_press;
            dir_n    = dn_press;
            state_n  = DELAY;
          end
        end

        DELAY, REPEAT: begin
          if (opp_press) begin
            step     = 1'b1;
            step_dir = ~dir;
            dir_n    = ~dir;
            cnt_n    = '0;
            state_n  = DELAY;
          end else if (both_press) begin
            cnt_n   = '0;
            state_n = IDLE;
          end else if (!held) begin
            cnt_n   = '0;
            state_n = IDLE;
          end else if (limit_hit) begin
            step    = 1'b1;
            cnt_n   = '0;
            state_n = REPEAT;
          end else begin
            cnt_n = cnt + CNTW'(1);
          end
        end

        default: begin
          cnt_n   = '0;
          state_n = IDLE;
        end
      endcase
    end
  end

  // Wrapping cursor arithmetic. UP decrements and DOWN increments.
  always_comb begin
    cursor_n = cursor;
    if (step) begin
      if (step_dir) begin
        cursor_n = (cursor == LAST_ITEM) ? '0 : cursor + CW'(1);
      end else begin
        cursor_n = (cursor == '0) ? LAST_ITEM : cursor - CW'(1);
      end
    end
  end

  assign sel_fire = enable & sel_press;

  // Everything visible at the ports is registered. sel_index captures the
  // current cursor value. If a step happens in the same cycle, sel_index
  // therefore reports the pre-step entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dir       <= 1'b0;
      cnt       <= '0;
      cursor    <= '0;
      moved     <= 1'b0;
      select    <= 1'b0;
      sel_index <= '0;
    end else begin
      state  <= state_n;
      dir    <= dir_n;
      cnt    <= cnt_n;
      cursor <= cursor_n;
      moved  <= step;
      select <= sel_fire;
      if (sel_fire) begin
        sel_index <= cursor;
      end
    end
  end

endmodule

// File: tb/tb_menu_cursor_ctrl.sv
// ---------------------------------------------------------------------------
// tb_menu_cursor_ctrl
//
// This is a self-checking bench for menu_cursor_ctrl, run with N_ITEMS=8,
// DELAY_CYC=10 and RATE_CYC=4. The reference model tracks the cycle of the
// last step and the gap until the next one. It does not count down a
// per-state counter.
// ---------------------------------------------------------------------------
module tb_menu_cursor_ctrl;

  localparam int N    = 8;
  localparam int DLY  = 10;
  localparam int RATE = 4;

  logic       clk = 1'b0;
  logic       reset, enable;
  logic       up_state, up_press, dn_state, dn_press, sel_press;
  logic [2:0] cursor, sel_index;
  logic       moved, select;

  always #5 clk = ~clk;

  menu_cursor_ctrl #(
    .N_ITEMS  (N),
    .DELAY_CYC(DLY),
    .RATE_CYC (RATE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .up_state (up_state),
    .up_press (up_press),
    .dn_state (dn_state),
    .dn_press (dn_press),
    .sel_press(sel_press),
    .cursor   (cursor),
    .moved    (moved),
    .select   (select),
    .sel_index(sel_index)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  int m_cursor, m_sel_index, m_last, m_gap, cyc;
  bit m_moved, m_select, m_active, m_dir;

  task automatic model_step();
    bit stp = 1'b0;
    bit hold;
    if (reset) begin
      m_cursor = 0; m_sel_index = 0; m_moved = 0; m_select = 0;
      m_active = 0; m_dir = 0;
    end else if (!enable) begin
      m_moved = 0; m_select = 0; m_active = 0;
    end else begin
      m_select = sel_press;
      if (sel_press) m_sel_index = m_cursor;
      hold = m_dir ? dn_state : up_state;
      if (!m_active) begin
        if (up_press != dn_press) begin
          stp = 1; m_dir = dn_press; m_active = 1; m_last = cyc; m_gap = DLY;
        end
      end else if ((m_dir ? up_press : dn_press) && !(up_press && dn_press)) begin
        stp = 1; m_dir = !m_dir; m_last = cyc; m_gap = DLY;
      end else if (up_press && dn_press) begin
        m_active = 0;
      end else if (!hold) begin
        m_active = 0;
      end else if (cyc - m_last == m_gap) begin
        stp = 1; m_last = cyc; m_gap = RATE;
      end
      m_moved = stp;
      if (stp) m_cursor = m_dir ? (m_cursor + 1) % N : (m_cursor + N - 1) % N;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [7:0] dut_v();
    return {cursor, moved, select, sel_index};
  endfunction

  function automatic logic [7:0] mdl_v();
    return {3'(m_cursor), m_moved, m_select, 3'(m_sel_index)};
  endfunction

  task automatic clear_inputs();
    reset = 0; enable = 1;
    up_state = 0; up_press = 0; dn_state = 0; dn_press = 0; sel_press = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1;
    tick();
    reset = 0;
  endtask

  // Single DOWN tap to move the cursor one entry.
  task automatic tap_down();
    dn_state = 1; dn_press = 1;
    tick();
    dn_press = 0; dn_state = 0;
    tick();
  endtask

  task automatic test_reset();
    int acts = 0;
    clear_inputs();
    reset = 1;
    tick();
    tick();
    reset = 0;
    n_cmp++;
    if (dut_v() !== 8'h00) begin
      n_err++;
      $display("FAIL reset_state got=%h expected=%h", dut_v(), 8'h00);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (dut_v() !== mdl_v()) begin
        n_err++;
        $display("FAIL reset_idle cyc=%0d got=%h expected=%h", i, dut_v(), mdl_v());
      end
      if (moved || select) acts++;
    end
    n_cmp++;
    if (acts !== 0 || cursor !== 3'd0) begin
      n_err++;
      $display("FAIL reset_quiet activity=%0d cursor=%0d expected 0/0", acts, cursor);
    end
  endtask

  task automatic test_single_up();
    int acts = 0;
    do_reset();
    up_state = 1; up_press = 1;
    tick();
    up_press = 0; up_state = 0;
    n_cmp++;
    if (cursor !== 3'd7 || moved !== 1'b1) begin
      n_err++;
      $display("FAIL single_up cursor=%0d moved=%b expected 7/1", cursor, moved);
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      n_cmp++;
      if (dut_v() !== mdl_v()) begin
        n_err++;
        $display("FAIL single_up_after cyc=%0d got=%h expected=%h", i, dut_v(), mdl_v());
      end
      if (moved) acts++;
    end
    n_cmp++;
    if (acts !== 0 || cursor !== 3'd7) begin
      n_err++;
      $display("FAIL single_up_idle moves=%0d cursor=%0d expected 0/7", acts, cursor);
    end
  endtask

  task automatic test_hold_down();
    int mv[$];
    int exp_mv[6] = '{1, 11, 15, 19, 23, 27};
    int late = 0;
    do_reset();
    for (int i = 0; i < 36; i++) begin
      dn_state = (i < 30);
      dn_press = (i == 0);
      tick();
      n_cmp++;
      if (dut_v() !== mdl_v()) begin
        n_err++;
        $display("FAIL hold_down cyc=%0d got=%h expected=%h", i, dut_v(), mdl_v());
      end
      if (moved) mv.push_back(i + 1);
    end
    n_cmp++;
    if (mv.size() != 6) begin
      n_err++;
      $display("FAIL hold_down_count got=%0d expected=6", mv.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_cmp++;
        if (mv[k] != exp_mv[k]) begin
          n_err++;
          $display("FAIL hold_down_time idx=%0d got=%0d expected=%0d", k, mv[k], exp_mv[k]);
        end
      end
    end
    n_cmp++;
    if (cursor !== 3'd6) begin
      n_err++;
      $display("FAIL hold_down_cursor got=%0d expected=6", cursor);
    end
    // Holding again without a press must not restart the FSM.
    dn_state = 1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (moved) late++;
    end
    dn_state = 0;
    n_cmp++;
    if (late !== 0) begin
      n_err++;
      $display("FAIL hold_down_idle moves=%0d expected=0", late);
    end
  endtask

  task automatic test_both_press();
    int acts = 0;
    do_reset();
    for (int i = 0; i < 3; i++) tap_down();
    n_cmp++;
    if (cursor !== 3'd3) begin
      n_err++;
      $display("FAIL both_setup cursor=%0d expected=3", cursor);
    end
    up_state = 1; dn_state = 1; up_press = 1; dn_press = 1;
    tick();
    up_press = 0; dn_press = 0;
    n_cmp++;
    if (moved !== 1'b0 || cursor !== 3'd3) begin
      n_err++;
      $display("FAIL both_press moved=%b cursor=%0d expected 0/3", moved, cursor);
    end
    for (int i = 0; i < 15; i++) begin
      tick();
      if (moved) acts++;
    end
    // A double press during DELAY drops back to IDLE even though DOWN stays held.
    up_state = 0;
    dn_press = 1;
    tick();
    dn_press = 0;
    for (int i = 0; i < 3; i++) tick();
    up_press = 1; dn_press = 1;
    tick();
    up_press = 0; dn_press = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_cmp++;
      if (dut_v() !== mdl_v()) begin
        n_err++;
        $display("FAIL both_in_delay cyc=%0d got=%h expected=%h", i, dut_v(), mdl_v());
      end
      if (moved) acts++;
    end
    dn_state = 0;
    n_cmp++;
    if (acts !== 0 || cursor !== 3'd4) begin
      n_err++;
      $display("FAIL both_idle moves=%0d cursor=%0d expected 0/4", acts, cursor);
    end
  endtask

  task automatic test_select_with_step();
    do_reset();
    for (int i = 0; i < 5; i++) tap_down();
    dn_state = 1; dn_press = 1; sel_press = 1;
    tick();
    dn_press = 0; sel_press = 0; dn_state = 0;
    n_cmp++;
    if (select !== 1'b1 || sel_index !== 3'd5 || cursor !== 3'd6 || moved !== 1'b1) begin
      n_err++;
      $display("FAIL select_step sel=%b idx=%0d cursor=%0d moved=%b expected 1/5/6/1",
               select, sel_index, cursor, moved);
    end
    tick();
    n_cmp++;
    if (select !== 1'b0 || sel_index !== 3'd5) begin
      n_err++;
      $display("FAIL select_hold sel=%b idx=%0d expected 0/5", select, sel_index);
    end
  endtask

  task automatic test_reset_mid_repeat();
    int late = 0;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      dn_state = 1;
      dn_press = (i == 0);
      reset    = (i == 17);
      tick();
      n_cmp++;
      if (dut_v() !== mdl_v()) begin
        n_err++;
        $display("FAIL reset_mid cyc=%0d got=%h expected=%h", i, dut_v(), mdl_v());
      end
      if (i == 17) begin
        n_cmp++;
        if (cursor !== 3'd0 || moved !== 1'b0) begin
          n_err++;
          $display("FAIL reset_mid_clear cursor=%0d moved=%b expected 0/0", cursor, moved);
        end
      end
      if (i > 17 && moved) late++;
    end
    reset = 0;
    n_cmp++;
    if (late !== 0) begin
      n_err++;
      $display("FAIL reset_mid_quiet moves=%0d expected=0", late);
    end
    dn_press = 1;
    tick();
    dn_press = 0; dn_state = 0;
    n_cmp++;
    if (moved !== 1'b1 || cursor !== 3'd1) begin
      n_err++;
      $display("FAIL reset_mid_repress moved=%b cursor=%0d expected 1/1", moved, cursor);
    end
  endtask

  task automatic test_enable_off();
    int acts = 0;
    do_reset();
    enable = 0; dn_state = 1; dn_press = 1; sel_press = 1;
    tick();
    dn_press = 0; sel_press = 0;
    n_cmp++;
    if (moved !== 1'b0 || select !== 1'b0 || cursor !== 3'd0) begin
      n_err++;
      $display("FAIL enable_off moved=%b sel=%b cursor=%0d expected 0/0/0", moved, select, cursor);
    end
    tick();
    enable = 1;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (moved) acts++;
    end
    n_cmp++;
    if (acts !== 0) begin
      n_err++;
      $display("FAIL enable_discard moves=%0d expected=0", acts);
    end
    // Disable mid-repeat: the hold is abandoned for good.
    dn_press = 1;
    tick();
    dn_press = 0;
    for (int i = 0; i < 30; i++) begin
      enable = (i != 14);
      tick();
      n_cmp++;
      if (dut_v() !== mdl_v()) begin
        n_err++;
        $display("FAIL enable_mid cyc=%0d got=%h expected=%h", i, dut_v(), mdl_v());
      end
    end
    dn_state = 0;
  endtask

  task automatic test_reversal();
    do_reset();
    dn_state = 1; dn_press = 1;
    tick();
    dn_press = 0;
    for (int i = 0; i < 30; i++) begin
      up_press = (i == 4);
      if (i == 4) up_state = 1;
      if (i == 6) dn_state = 0;
      tick();
      n_cmp++;
      if (dut_v() !== mdl_v()) begin
        n_err++;
        $display("FAIL reversal cyc=%0d got=%h expected=%h", i, dut_v(), mdl_v());
      end
    end
    up_state = 0; up_press = 0;
  endtask

  task automatic test_random();
    logic nu, nd;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      nu = ($urandom_range(23) == 0) ? ~up_state : up_state;
      nd = ($urandom_range(23) == 0) ? ~dn_state : dn_state;
      up_press  = (nu & ~up_state) | ($urandom_range(63) == 0);
      dn_press  = (nd & ~dn_state) | ($urandom_range(63) == 0);
      up_state  = nu;
      dn_state  = nd;
      sel_press = ($urandom_range(15) == 0);
      enable    = ($urandom_range(31) != 0);
      reset     = ($urandom_range(255) == 0);
      tick();
      n_cmp++;
      if (dut_v() !== mdl_v()) begin
        n_err++;
        $display("FAIL random cyc=%0d got=%h expected=%h", i, dut_v(), mdl_v());
      end
    end
    clear_inputs();
  endtask

  initial begin
    cyc = 0;
    m_cursor = 0; m_sel_index = 0; m_last = 0; m_gap = DLY;
    m_moved = 0; m_select = 0; m_active = 0; m_dir = 0;
    clear_inputs();
    test_reset();
    test_single_up();
    test_hold_down();
    test_both_press();
    test_select_with_step();
    test_reset_mid_repeat();
    test_enable_off();
    test_reversal();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
